bist_sig_unloader: RTL

- Response-side unload path of the LBIST: at end of test, transmits the compacted MISR signature off-chip as a serial frame.
- Lets the tester read the raw signature rather than only the pass/fail result.
- Sits beside the BIST controller and MISR; driven by the controller's end-of-test flag, fed by the MISR signature bus.
- Also produces a registered on-chip golden compare of the same captured value.

---
 rtl/bist_sig_unloader.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/bist_sig_unloader.sv
// LBIST signature unloader: at end of test, captures the MISR signature and
// shifts it off-chip as a frame: start(0), N data bits LSB first, even parity,
// stop(1). Every bit is held BIT_DIV clocks. A registered golden compare of the
// same captured value is presented on PASS.
module bist_sig_unloader #(
  parameter int              N                = 64,
  parameter int              BIT_DIV          = 4,
  parameter logic [N-1:0]    GOLDEN_SIGNATURE = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         END_TEST,
  input  logic [N-1:0] SIGNATURE,
  output logic         TX_O,
  output logic         BUSY,
  output logic         DONE,
  output logic         PASS
);

  // Counter widths; the divider keeps at least one bit so BIT_DIV=1 is legal.
  localparam int DW = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
  localparam int BW = $clog2(N);

  localparam logic [DW-1:0] DIV_LAST = DW'(BIT_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_DONE
  } state_t;

  state_t         state;
  logic [N-1:0]   shift_q;
  logic           par_q;
  logic [DW-1:0]  div_cnt;
  logic [BW-1:0]  bit_cnt;
  logic           end_test_q;
  logic           armed;
  logic           launch;
  logic           bit_end;

  // A launch needs a genuine low-to-high transition seen after reset. The
  // armed flag blocks a level that was already high when reset was released.
  assign launch  = END_TEST & ~end_test_q & armed;
  assign bit_end = (div_cnt == DIV_LAST);

  // Edge-detect register and arming flag for the end-of-test level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      end_test_q <= 1'b0;
      armed      <= 1'b0;
    end else begin
      end_test_q <= END_TEST;
      if (!END_TEST) armed <= 1'b1;
    end
  end

  // Frame FSM; TX_O/BUSY/DONE are set together with the state they belong to,
  // so every output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_IDLE;
      shift_q <= '0;
      par_q   <= 1'b0;
      div_cnt <= '0;
      bit_cnt <= '0;
      TX_O    <= 1'b1;
      BUSY    <= 1'b0;
      DONE    <= 1'b0;
      PASS    <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          TX_O <= 1'b1;
          if (launch) begin
            shift_q <= SIGNATURE;
            par_q   <= ^SIGNATURE;
            PASS    <= (SIGNATURE == GOLDEN_SIGNATURE);
            div_cnt <= '0;
            bit_cnt <= '0;
            TX_O    <= 1'b0;
            BUSY    <= 1'b1;
            state   <= S_START;
          end
        end

        S_START: begin
          if (bit_end) begin
            div_cnt <= '0;
            bit_cnt <= '0;
            TX_O    <= shift_q[0];
            state   <= S_DATA;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            div_cnt <= '0;
            shift_q <= shift_q >> 1;
            if (bit_cnt == BIT_LAST) begin
              bit_cnt <= '0;
              TX_O    <= par_q;
              state   <= S_PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
              // Next bit is the one about to land in position 0.
              TX_O    <= shift_q[1];
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_PARITY: begin
          if (bit_end) begin
            div_cnt <= '0;
            TX_O    <= 1'b1;
            state   <= S_STOP;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            div_cnt <= '0;
            TX_O    <= 1'b1;
            BUSY    <= 1'b0;
            DONE    <= 1'b1;
            state   <= S_DONE;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end

        S_DONE: begin
          TX_O <= 1'b1;
          BUSY <= 1'b0;
          if (!END_TEST) begin
            DONE    <= 1'b0;
            div_cnt <= '0;
            state   <= S_IDLE;
          end
        end

        default: begin
          TX_O    <= 1'b1;
          BUSY    <= 1'b0;
          DONE    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

endmodule
